// File: rtl/seg7_bcd_scan_if.sv
// -----------------------------------------------------------------------------
// seg7_bcd_scan_if
// Purpose : groups the conversion request handshake between the IO write path
//           and the seven-segment controller.
// Signals :
//   load    master -> slave  request conversion of bin_in
//   bin_in  master -> slave  unsigned binary value to display
//   busy    slave  -> master conversion in progress
//   done    slave  -> master one-cycle pulse when the new value is displayed
//
// Handshake: load is a request qualified by busy. It is accepted on a rising
// clock edge only when busy=0 at that edge. A load while busy=1 is dropped
// with no queueing and no error. busy rises after the accepting edge and stays
// high until the value has been copied to the display register. done pulses
// for one cycle after busy falls, and a load in that cycle is accepted.
// -----------------------------------------------------------------------------
interface seg7_bcd_scan_if #(
  parameter int DATA_W = 16
);
  logic              load;
  logic [DATA_W-1:0] bin_in;
  logic              busy;
  logic              done;

  modport master (output load, output bin_in, input busy, input done);
  modport slave  (input load, input bin_in, output busy, output done);
endinterface

// File: rtl/seg7_bcd_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg7_bcd_scan_ctrl
// Purpose : drives an 8-digit seven-segment bank from an IO write value.
//           A sequential double-dabble converter turns the binary value into
//           BCD digits. The digits are double-buffered in a display register
//           and scanned time-multiplexed onto one shared segment bus.
// Ports   :
//   clock        system clock
//   rst          asynchronous reset, active-low
//   bus          seg7_bcd_scan_if.slave (load, bin_in, busy, done)
//   seg_out      [6:0]=g..a, [7]=dp (dp always off), registered
//   digit_en     one-hot digit select, bit i = digit i, registered
//   fsm_state_o  converter FSM state for debug (0=IDLE 1=SHIFT 2=LOAD)
// Configuration:
//   SEG7_LEADING_BLANK_EN  when defined, digits above the most significant
//                          non-zero digit keep digit_en inactive. Digit 0 is
//                          always shown. Slot timing is unchanged.
// -----------------------------------------------------------------------------
module seg7_bcd_scan_ctrl #(
  parameter int DATA_W         = 16,
  parameter int DIGITS         = 8,
  parameter int REFRESH_DIV    = 100000,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic              clock,
  input  logic              rst,
  seg7_bcd_scan_if.slave    bus,
  output logic [7:0]        seg_out,
  output logic [DIGITS-1:0] digit_en,
  output logic [1:0]        fsm_state_o
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam int SCAN_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic POL  = (SEG_ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic [BCD_W-1:0]    bcd_adj;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BCD_W-1:0]    disp_q, disp_d;
  logic                done_q, done_d;

  logic [SCAN_W-1:0]   scan_q, scan_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   en_q, en_d;
  logic [DIGITS-1:0]   en_mask;
  logic [3:0]          nib_cur;

  // ---------------------------------------------------------------------------
  // Double-dabble: corrections use the pre-shift BCD value of the same cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.load) begin
          bin_d   = bus.bin_in;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bcd_d = {bcd_adj[BCD_W-2:0], bin_q[DATA_W-1]};
        bin_d = {bin_q[DATA_W-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        // This edge performs the last of DATA_W shifts.
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        disp_d  = bcd_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.done    = done_q;
  assign fsm_state_o = state_q;

  // ---------------------------------------------------------------------------
  // Leading-zero blank mask, captured alongside the display register so the
  // scan never sees a mask that disagrees with the digits it shows.
  // ---------------------------------------------------------------------------
`ifdef SEG7_LEADING_BLANK_EN
  logic [DIGITS-1:0] show_q, show_d, show_calc;
  logic              any_nz;

  always_comb begin
    any_nz    = 1'b0;
    show_calc = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      any_nz       = any_nz | (bcd_q[4*i +: 4] != 4'd0);
      show_calc[i] = any_nz | (i == 0);
    end
    show_d = (state_q == ST_LOAD) ? show_calc : show_q;
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      show_q <= DIGITS'(1);
    end else begin
      show_q <= show_d;
    end
  end

  assign en_mask = show_q;
`else
  assign en_mask = '1;
`endif

  // ---------------------------------------------------------------------------
  // Scan: free-running slot counter, independent of the converter FSM.
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h00;
    endcase
  endfunction

  always_comb begin
    scan_d = scan_q + 1'b1;
    idx_d  = idx_q;
    if (scan_q == SCAN_W'(REFRESH_DIV - 1)) begin
      scan_d = '0;
      idx_d  = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
    nib_cur = disp_q[{idx_q, 2'b00} +: 4];
    // Polarity is applied here so the pins see a clean registered value.
    seg_d   = {1'b0, seg_decode(nib_cur)} ^ {8{POL}};
    en_d    = ((DIGITS'(1) << idx_q) & en_mask) ^ {DIGITS{POL}};
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      scan_q <= '0;
      idx_q  <= '0;
      seg_q  <= {8{POL}};
      en_q   <= {DIGITS{POL}};
    end else begin
      scan_q <= scan_d;
      idx_q  <= idx_d;
      seg_q  <= seg_d;
      en_q   <= en_d;
    end
  end

  assign seg_out  = seg_q;
  assign digit_en = en_q;

endmodule

// File: tb/tb_seg7_bcd_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg7_bcd_scan_ctrl
// Randomized and directed stimulus against a decimal reference model: digit
// values come from integer divide/modulo of the loaded value, the active slot
// from the clock count since reset release.
// -----------------------------------------------------------------------------
module tb_seg7_bcd_scan_ctrl;
  localparam int DATA_W      = 16;
  localparam int DIGITS      = 8;
  localparam int REFRESH_DIV = 4;
  localparam int CONV_CYC    = DATA_W + 1;

  logic              clock = 1'b0;
  logic              rst   = 1'b0;
  logic [7:0]        seg_out;
  logic [DIGITS-1:0] digit_en;
  logic [1:0]        fsm_state;

  int checks   = 0;
  int failures = 0;
  int cyc;
  int disp_model = 0;

  logic [7:0] seg_tab [0:9] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  seg7_bcd_scan_if #(.DATA_W(DATA_W)) bus ();

  seg7_bcd_scan_ctrl #(
    .DATA_W(DATA_W), .DIGITS(DIGITS), .REFRESH_DIV(REFRESH_DIV), .SEG_ACTIVE_LOW(1)
  ) dut (
    .clock(clock), .rst(rst), .bus(bus),
    .seg_out(seg_out), .digit_en(digit_en), .fsm_state_o(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  // Edges since reset release; the scan slot shown after edge k is (k-1)/REFRESH_DIV.
  always @(posedge clock or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int pow10(input int s);
    int r = 1;
    for (int i = 0; i < s; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [7:0] exp_seg(input int v, input int s);
    return ~seg_tab[(v / pow10(s)) % 10];
  endfunction

  function automatic logic [7:0] exp_en(input int v, input int s);
    bit shown = 1'b1;
`ifdef SEG7_LEADING_BLANK_EN
    shown = (s == 0) || (v >= pow10(s));
`endif
    return shown ? ~(8'(1) << s) : 8'hFF;
  endfunction

  function automatic int cur_slot();
    return ((cyc - 1) / REFRESH_DIV) % DIGITS;
  endfunction

  // ---------------- drivers / monitors ----------------
  task automatic start_load(input int v);
    bus.load   = 1'b1;
    bus.bin_in = DATA_W'(v);
    @(negedge clock);
    bus.load   = 1'b0;
  endtask

  // Samples the busy window, noting how many samples disagree with the
  // displayed (old) value. Returns at the first sample with busy low.
  task automatic wait_done(input int old_v, output int busy_cnt, output int bad);
    busy_cnt = 0;
    bad      = 0;
    for (int i = 0; i < 100 && bus.busy === 1'b1; i++) begin
      if ({digit_en, seg_out} !== {exp_en(old_v, cur_slot()), exp_seg(old_v, cur_slot())}) bad++;
      busy_cnt++;
      @(negedge clock);
    end
    if ({digit_en, seg_out} !== {exp_en(old_v, cur_slot()), exp_seg(old_v, cur_slot())}) bad++;
  endtask

  // Observes n idle cycles; records the first disagreement with the model.
  task automatic watch(input int v, input int n, output int bad,
                       output logic [15:0] got, output logic [15:0] want);
    logic [15:0] e;
    bad = 0; got = '0; want = '0;
    for (int i = 0; i < n; i++) begin
      e = {exp_en(v, cur_slot()), exp_seg(v, cur_slot())};
      if ({digit_en, seg_out} !== e || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        if (bad == 0) begin got = {digit_en, seg_out}; want = e; end
        bad++;
      end
      @(negedge clock);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int bad; logic [15:0] g, w;
    bus.load = 1'b0; bus.bin_in = '0; rst = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++; $display("FAIL reset_flags: busy=%b done=%b, want 0 0", bus.busy, bus.done);
    end
    checks++;
    if (seg_out !== 8'hFF || digit_en !== 8'hFF) begin
      failures++; $display("FAIL reset_pins: seg=%h en=%h, want FF FF", seg_out, digit_en);
    end
    checks++;
    if (fsm_state !== 2'd0) begin
      failures++; $display("FAIL reset_state: state=%0d, want 0", fsm_state);
    end
    rst = 1'b1;
    disp_model = 0;
    @(negedge clock);
    watch(0, 40, bad, g, w);
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL reset_scan: %0d bad cycles, first en/seg=%h want %h", bad, g, w);
    end
  endtask

  task automatic test_convert(input int v);
    int bc, bad; logic [15:0] g, w;
    start_load(v);
    wait_done(disp_model, bc, bad);
    checks++;
    if (bc !== CONV_CYC) begin
      failures++; $display("FAIL conv_busy_len v=%0d: busy %0d cycles, want %0d", v, bc, CONV_CYC);
    end
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL conv_old_display v=%0d: %0d samples changed, want 0", v, bad);
    end
    checks++;
    if (bus.done !== 1'b1) begin
      failures++; $display("FAIL conv_done v=%0d: done=%b after busy fell, want 1", v, bus.done);
    end
    @(negedge clock);
    checks++;
    if (bus.done !== 1'b0) begin
      failures++; $display("FAIL conv_done_width v=%0d: done=%b second cycle, want 0", v, bus.done);
    end
    disp_model = v;
    watch(v, 36, bad, g, w);
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL conv_scan v=%0d: %0d bad cycles, first en/seg=%h want %h", v, bad, g, w);
    end
  endtask

  task automatic test_drop();
    int bc, bad; logic [15:0] g, w;
    start_load(100);
    repeat (2) @(negedge clock);
    start_load(7);  // seen three edges after the accepted load
    wait_done(disp_model, bc, bad);
    checks++;
    if (bc !== CONV_CYC - 3) begin
      failures++; $display("FAIL drop_busy_len: %0d remaining busy cycles, want %0d", bc, CONV_CYC - 3);
    end
    checks++;
    if (bus.done !== 1'b1) begin
      failures++; $display("FAIL drop_done: done=%b, want 1", bus.done);
    end
    @(negedge clock);
    disp_model = 100;
    watch(100, 40, bad, g, w);
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL drop_scan: %0d bad cycles, first en/seg=%h want %h", bad, g, w);
    end
  endtask

  task automatic test_back_to_back();
    int bc, bad; logic [15:0] g, w;
    start_load(777);
    wait_done(disp_model, bc, bad);
    checks++;
    if (bus.done !== 1'b1 || bc !== CONV_CYC) begin
      failures++; $display("FAIL b2b_first: done=%b busy=%0d, want 1 %0d", bus.done, bc, CONV_CYC);
    end
    disp_model = 777;
    start_load(31415);  // issued in the done cycle
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++; $display("FAIL b2b_accept: busy=%b, want 1", bus.busy);
    end
    wait_done(disp_model, bc, bad);
    checks++;
    if (bc !== CONV_CYC || bad !== 0 || bus.done !== 1'b1) begin
      failures++; $display("FAIL b2b_second: busy=%0d bad=%0d done=%b, want %0d 0 1", bc, bad, bus.done, CONV_CYC);
    end
    @(negedge clock);
    disp_model = 31415;
    watch(31415, 36, bad, g, w);
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL b2b_scan: %0d bad cycles, first en/seg=%h want %h", bad, g, w);
    end
  endtask

  task automatic test_reset_mid();
    int bad; logic [15:0] g, w;
    start_load(9999);
    repeat (5) @(negedge clock);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++; $display("FAIL midrst_flags: busy=%b done=%b, want 0 0", bus.busy, bus.done);
    end
    checks++;
    if (seg_out !== 8'hFF || digit_en !== 8'hFF) begin
      failures++; $display("FAIL midrst_pins: seg=%h en=%h, want FF FF", seg_out, digit_en);
    end
    @(negedge clock);
    rst = 1'b1;
    disp_model = 0;
    @(negedge clock);
    watch(0, 40, bad, g, w);  // also catches any late done pulse
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL midrst_scan: %0d bad cycles, first en/seg=%h want %h", bad, g, w);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) test_convert(int'($urandom_range(0, 65535)));
  endtask

  initial begin
    test_reset();
    test_convert(12345);
    test_convert(65535);
    test_convert(0);
    test_drop();
    test_convert(42);
    test_convert(0);
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
